div_seq: RTL and testbench



---
 rtl/div_seq_pkg.sv | 21 ++
 rtl/div_seq_step.sv | 28 ++
 rtl/div_seq.sv | 172 +++++++++++++++++
 tb/tb_div_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared encodings for the multi-cycle divider.
//   DIV_*              : 2-bit FSM state encodings
//   DIV_RESULT_*       : ready_o levels
//   DIV_START/DIV_STOP : start_i levels
//   REG_BUS_W          : datapath word width
package div_seq_pkg;

  localparam logic [1:0] DIV_FREE   = 2'b00;
  localparam logic [1:0] DIV_BYZERO = 2'b01;
  localparam logic [1:0] DIV_ON     = 2'b10;
  localparam logic [1:0] DIV_END    = 2'b11;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam int REG_BUS_W = 32;

endpackage

// File: rtl/div_seq_step.sv
// div_seq_step: one restoring shift-subtract iteration (combinational).
// Ports:
//   dividend_i [2W-1:0] : low 2W bits of the working dividend register
//   divisor_i  [W-1:0]  : magnitude of the divisor
//   dividend_o [2W:0]   : working dividend register after this iteration
module div_step
  import div_seq_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W
) (
  input  logic [2*DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0]   divisor_i,
  output logic [2*DATA_W:0]   dividend_o
);

  logic [DATA_W:0] diff;

  always_comb begin
    diff = {1'b0, dividend_i[2*DATA_W-1:DATA_W]} - {1'b0, divisor_i};
    // Borrow out means the partial remainder was smaller than the divisor.
    if (diff[DATA_W]) begin
      dividend_o = {dividend_i, 1'b0};
    end else begin
      dividend_o = {diff[DATA_W-1:0], dividend_i[DATA_W-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle DIV/DIVU sequencer, one quotient bit per clock.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   signed_div_i          : 1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i / opdata2_i : dividend / divisor
//   start_i               : request, held until the result is consumed
//   annul_i               : abort a division in progress
//   result_o              : {remainder, quotient}
//   ready_o               : result valid
//   divzero_o             : divisor was zero
// Build option: DIV_BYZERO_FLAG_EN registers divzero_o; without it the
// flag is tied low and divide-by-zero still returns 0 with normal timing.
//
// state      | meaning
// DIV_FREE   | idle, waiting for start_i
// DIV_BYZERO | divisor was zero, result forced to 0
// DIV_ON     | iterating, one quotient bit per clock
// DIV_END    | result held until start_i drops
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  divzero_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W:0]   dividend_q, dividend_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [2*DATA_W:0]   step_dividend;
  logic [DATA_W-1:0]   abs_op1, abs_op2;
  logic [DATA_W-1:0]   quot, rem;

  div_step #(.DATA_W(DATA_W)) u_step (
    .dividend_i (dividend_q[2*DATA_W-1:0]),
    .divisor_i  (divisor_q),
    .dividend_o (step_dividend)
  );

  always_comb begin
    abs_op1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    abs_op2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    quot       = neg_quot_q ? -dividend_q[DATA_W-1:0] : dividend_q[DATA_W-1:0];
    rem        = neg_rem_q ? -dividend_q[2*DATA_W:DATA_W+1]
                           : dividend_q[2*DATA_W:DATA_W+1];
    case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d    = DIV_ON;
            cnt_d      = '0;
            dividend_d = {{DATA_W{1'b0}}, abs_op1, 1'b0};
            divisor_d  = abs_op2;
            // Signs are captured here so later operand changes are harmless.
            neg_quot_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_d  = signed_div_i && opdata1_i[DATA_W-1];
          end
        end
      end
      DIV_BYZERO: begin
        result_d = '0;
        ready_d  = DIV_RESULT_READY;
        state_d  = DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d    = DIV_FREE;
          cnt_d      = '0;
          dividend_d = '0;
          divisor_d  = '0;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          dividend_d = step_dividend;
          cnt_d      = cnt_q + CNT_W'(1);
        end else begin
          result_d = {rem, quot};
          ready_d  = DIV_RESULT_READY;
          cnt_d    = '0;
          state_d  = DIV_END;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

`ifdef DIV_BYZERO_FLAG_EN
  logic divzero_q, divzero_d;

  always_comb begin
    divzero_d = divzero_q;
    if (state_q == DIV_BYZERO) begin
      divzero_d = 1'b1;
    end else if (state_q == DIV_END && start_i == DIV_STOP) begin
      divzero_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divzero_q <= 1'b0;
    end else begin
      divzero_q <= divzero_d;
    end
  end

  assign divzero_o = divzero_q;
`else
  assign divzero_o = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        divzero_o;

  always #5 clk = ~clk;

  div_seq #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .divzero_o    (divzero_o)
  );

`ifdef DIV_BYZERO_FLAG_EN
  localparam logic DZ_EXP = 1'b1;
`else
  localparam logic DZ_EXP = 1'b0;
`endif

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          rise;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every rising ready_o consumes one scoreboard entry.
  always @(negedge clk) begin
    if (ready_o === 1'b1 && prev_ready !== 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready actual=1 required=0 at cycle %0d", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", result_o, mon_e.res);
        check("divzero", {63'b0, divzero_o}, {63'b0, mon_e.dz});
        check("latency_cycle", 64'(cyc), 64'(mon_e.rise));
      end
    end
    prev_ready <= ready_o;
  end

  // Called at a negedge with the DUT in FREE.
  task automatic run_div(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input logic exp_dz, input int lat);
    exp_t e;
    int   n;
    e.res  = exp_res;
    e.dz   = exp_dz;
    e.rise = cyc + lat;
    sb_q.push_back(e);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    opdata1_i    = ~a;
    opdata2_i    = b ^ 32'h0000_0005;
    signed_div_i = ~s;
    n = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout actual=%b required=1", name, ready_o);
    end
    repeat (2) begin
      @(negedge clk);
      check({name, "_hold_ready"}, {63'b0, ready_o}, 64'd1);
      check({name, "_hold_result"}, result_o, exp_res);
    end
    start_i = 1'b0;
    @(negedge clk);
    check({name, "_drop_ready"}, {63'b0, ready_o}, 64'd0);
    check({name, "_drop_result"}, result_o, 64'd0);
    check({name, "_drop_divzero"}, {63'b0, divzero_o}, 64'd0);
  endtask

  task automatic watch_no_ready(input string name, input int ncyc);
    logic rose;
    rose = 1'b0;
    repeat (ncyc) begin
      @(negedge clk);
      if (ready_o !== 1'b0) rose = 1'b1;
    end
    check(name, {63'b0, rose}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", {63'b0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_divzero", {63'b0, divzero_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div("divu_100_7",  1'b0, 32'd100,      32'd7,        {32'h2, 32'hE},                 1'b0, 34);
    run_div("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,       {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 34);
    run_div("div_7_m2",    1'b1, 32'd7,        32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD},        1'b0, 34);
    run_div("div_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000},       1'b0, 34);
    run_div("divu_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,        {32'h0, 32'hFFFF_FFFF},        1'b0, 34);
    run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'hE},       1'b0, 34);
    run_div("divu_msb_16", 1'b0, 32'h8000_0000, 32'd16,       {32'h0, 32'h0800_0000},        1'b0, 34);
    run_div("divu_3_5",    1'b0, 32'd3,        32'd5,         {32'h3, 32'h0},                1'b0, 34);
    run_div("div_byzero",  1'b0, 32'd5,        32'd0,         64'd0,                         DZ_EXP, 2);

    // Abort mid-iteration: no result may appear.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    watch_no_ready("annul_no_ready", 50);
    run_div("divu_9_3_after_annul", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 1'b0, 34);

    // start_i and annul_i together in FREE: not accepted.
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
    annul_i   = 1'b0;
    watch_no_ready("start_annul_no_ready", 50);

    // Reset mid-iteration.
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    repeat (21) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check("rst_on_ready", {63'b0, ready_o}, 64'd0);
    check("rst_on_result", result_o, 64'd0);
    check("rst_on_divzero", {63'b0, divzero_o}, 64'd0);
    rst = 1'b0;
    watch_no_ready("rst_on_no_ready", 50);

    // Reset while a result is held in END.
    begin
      exp_t e;
      int   n;
      e.res  = {32'h1, 32'h3};
      e.dz   = 1'b0;
      e.rise = cyc + 34;
      sb_q.push_back(e);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd13;
      opdata2_i    = 32'd4;
      start_i      = 1'b1;
      n = 0;
      @(negedge clk);
      while (ready_o !== 1'b1 && n < 60) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (ready_o !== 1'b1) begin
        errors++;
        $display("FAIL rst_end_timeout actual=%b required=1", ready_o);
      end
      rst = 1'b1;
      @(negedge clk);
      check("rst_end_ready", {63'b0, ready_o}, 64'd0);
      check("rst_end_result", result_o, 64'd0);
      start_i = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
